// File: rtl/vga_pkg.sv
// Timing constants for the supported VGA modes plus a constant-function clog2
// used to size counters and coordinate ports.
package vga_pkg;

   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam bit VGA640_H_POL    = 1'b0;
   localparam bit VGA640_V_POL    = 1'b0;

   localparam int SVGA800_H_ACTIVE = 800;
   localparam int SVGA800_H_FP     = 40;
   localparam int SVGA800_H_SYNC   = 128;
   localparam int SVGA800_H_BP     = 88;
   localparam int SVGA800_V_ACTIVE = 600;
   localparam int SVGA800_V_FP     = 1;
   localparam int SVGA800_V_SYNC   = 4;
   localparam int SVGA800_V_BP     = 23;
   localparam bit SVGA800_H_POL    = 1'b1;
   localparam bit SVGA800_V_POL    = 1'b1;

   // Never returns less than 1 so that a port width is always legal.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register pipeline; DEPTH=0 degenerates to a wire.
module vga_delay_line
   import vga_pkg::*;
#(
   parameter int               WIDTH     = 3,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign data_o = data_i;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage_q [DEPTH];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage_q[i] <= RESET_VAL;
               end
            end else begin
               stage_q[0] <= data_i;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_q[i] <= stage_q[i-1];
               end
            end
         end

         assign data_o = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: counters, pixel requests, and a DAC output
// stage whose sync/blank are delayed to match the pixel-source latency.
module vga_timing_param
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter bit H_POL    = VGA640_H_POL,
   parameter bit V_POL    = VGA640_V_POL,
   parameter int COLOR_W  = 8,
   parameter int PIX_LAT  = 1,
   parameter bit SOG      = 1'b0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [COLOR_W-1:0]            pix_r,
   input  logic [COLOR_W-1:0]            pix_g,
   input  logic [COLOR_W-1:0]            pix_b,
   output logic                          pix_valid,
   output logic [clog2(H_ACTIVE)-1:0]    x,
   output logic [clog2(V_ACTIVE)-1:0]    y,
   output logic                          frame_start,
   output logic                          line_start,
   output logic [COLOR_W-1:0]            red,
   output logic [COLOR_W-1:0]            green,
   output logic [COLOR_W-1:0]            blue,
   output logic                          h_sync,
   output logic                          v_sync,
   output logic                          blank_n,
   output logic                          sync_n
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HCW     = clog2(H_TOTAL);
   localparam int VCW     = clog2(V_TOTAL);
   localparam int XW      = clog2(H_ACTIVE);
   localparam int YW      = clog2(V_ACTIVE);

   localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
   localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
   localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
   localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
   localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
   localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
   localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HCW-1:0]     hCnt_q, hCnt_d;
   logic [VCW-1:0]     vCnt_q, vCnt_d;
   logic               activeRaw, hsRaw, vsRaw;
   logic               dlyActive, dlyHs, dlyVs;
   logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic               hSync_q, hSync_d, vSync_q, vSync_d;
   logic               blank_q, syncN_q, syncN_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hCnt_q <= '0;
         vCnt_q <= '0;
      end else begin
         hCnt_q <= hCnt_d;
         vCnt_q <= vCnt_d;
      end
   end

   always_comb begin
      hCnt_d = hCnt_q + 1'b1;
      vCnt_d = vCnt_q;
      if (hCnt_q == H_LAST) begin
         hCnt_d = '0;
         vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 1'b1;
      end
   end

   always_comb begin
      activeRaw = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
      hsRaw     = (hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END);
      vsRaw     = (vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END);
   end

   // Request-side strobes are gated by reset so they read inactive while held.
   assign pix_valid   = activeRaw & ~reset;
   assign x           = pix_valid ? hCnt_q[XW-1:0] : '0;
   assign y           = pix_valid ? vCnt_q[YW-1:0] : '0;
   assign frame_start = ~reset & (hCnt_q == '0) & (vCnt_q == '0);
   assign line_start  = ~reset & (hCnt_q == '0) & (vCnt_q < V_ACT_END);

   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIX_LAT),
      .RESET_VAL (3'b000)
   ) u_delay (
      .clk    (clk),
      .reset  (reset),
      .data_i ({activeRaw, hsRaw, vsRaw}),
      .data_o ({dlyActive, dlyHs, dlyVs})
   );

   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (dlyActive) begin
         red_d   = pix_r;
         green_d = pix_g;
         blue_d  = pix_b;
      end
      hSync_d = dlyHs ? H_POL : ~H_POL;
      vSync_d = dlyVs ? V_POL : ~V_POL;
      syncN_d = SOG ? ~(dlyHs | dlyVs) : 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         blank_q <= 1'b0;
         hSync_q <= ~H_POL;
         vSync_q <= ~V_POL;
         syncN_q <= 1'b1;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         blank_q <= dlyActive;
         hSync_q <= hSync_d;
         vSync_q <= vSync_d;
         syncN_q <= syncN_d;
      end
   end

   assign red     = red_q;
   assign green   = green_q;
   assign blue    = blue_q;
   assign blank_n = blank_q;
   assign h_sync  = hSync_q;
   assign v_sync  = vSync_q;
   assign sync_n  = syncN_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: two scaled-down modes (negative sync with PIX_LAT=2,
// positive sync with SOG and PIX_LAT=0) checked against a cycle model and scoreboard.
`timescale 1ns/1ps
module tb_vga_timing_param;
   import vga_pkg::*;

   localparam int H_ACT[2] = '{16, 12};
   localparam int H_FPO[2] = '{2, 3};
   localparam int H_SW[2]  = '{3, 4};
   localparam int H_BPO[2] = '{4, 5};
   localparam int V_ACT[2] = '{6, 5};
   localparam int V_FPO[2] = '{1, 2};
   localparam int V_SW[2]  = '{2, 3};
   localparam int V_BPO[2] = '{1, 1};
   localparam bit H_PL[2]  = '{1'b0, 1'b1};
   localparam bit V_PL[2]  = '{1'b0, 1'b1};
   localparam int LAT[2]   = '{2, 0};
   localparam bit SOGP[2]  = '{1'b0, 1'b1};

   typedef struct {
      int         due;
      logic       act;
      logic       hs;
      logic       vs;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } sbEntry_t;

   typedef struct {
      int   k;
      int   h;
      int   v;
      logic pv;
      int   x;
      int   y;
      logic fs;
      logic ls;
   } probe_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] pixR[2], pixG[2], pixB[2];
   logic       pvO[2], fsO[2], lsO[2];
   logic [3:0] xO[2];
   logic [2:0] yO[2];
   logic [7:0] redO[2], greenO[2], blueO[2];
   logic       hsO[2], vsO[2], blankO[2], syncNO[2];

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc;
   bit         inReset;
   int         mh[2], mv[2];
   logic [7:0] histR[2][8], histG[2][8], histB[2][8];
   sbEntry_t   sbQ0[$], sbQ1[$];
   probe_t     probes[12];

   always #5 clk = ~clk;

   vga_timing_param #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(1'b0), .V_POL(1'b0), .COLOR_W(8), .PIX_LAT(2), .SOG(1'b0)
   ) dutA (
      .clk(clk), .reset(reset),
      .pix_r(pixR[0]), .pix_g(pixG[0]), .pix_b(pixB[0]),
      .pix_valid(pvO[0]), .x(xO[0]), .y(yO[0]),
      .frame_start(fsO[0]), .line_start(lsO[0]),
      .red(redO[0]), .green(greenO[0]), .blue(blueO[0]),
      .h_sync(hsO[0]), .v_sync(vsO[0]), .blank_n(blankO[0]), .sync_n(syncNO[0])
   );

   vga_timing_param #(
      .H_ACTIVE(12), .H_FP(3), .H_SYNC(4), .H_BP(5),
      .V_ACTIVE(5), .V_FP(2), .V_SYNC(3), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .COLOR_W(8), .PIX_LAT(0), .SOG(1'b1)
   ) dutB (
      .clk(clk), .reset(reset),
      .pix_r(pixR[1]), .pix_g(pixG[1]), .pix_b(pixB[1]),
      .pix_valid(pvO[1]), .x(xO[1]), .y(yO[1]),
      .frame_start(fsO[1]), .line_start(lsO[1]),
      .red(redO[1]), .green(greenO[1]), .blue(blueO[1]),
      .h_sync(hsO[1]), .v_sync(vsO[1]), .blank_n(blankO[1]), .sync_n(syncNO[1])
   );

   function automatic int hTot(input int k);
      return H_ACT[k] + H_FPO[k] + H_SW[k] + H_BPO[k];
   endfunction

   function automatic int vTot(input int k);
      return V_ACT[k] + V_FPO[k] + V_SW[k] + V_BPO[k];
   endfunction

   function automatic logic [7:0] colR(input int xv);
      return 8'(xv + 16);
   endfunction

   function automatic logic [7:0] colG(input int yv);
      return 8'(yv + 64);
   endfunction

   function automatic logic [7:0] colB(input int xv, input int yv);
      return 8'((xv ^ yv) ^ 32'hC3);
   endfunction

   task automatic checkVal(input string name, input int k, input logic [31:0] actual,
                           input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s dut%0d: got %0d, expected %0d", name, k, actual, expected);
      end
   endtask

   // The pixel source answers each request PIX_LAT clocks later.
   task automatic applyStimulus(input int k);
      int idx;
      if (cyc >= LAT[k]) begin
         idx = (cyc - LAT[k]) % 8;
         pixR[k] = histR[k][idx];
         pixG[k] = histG[k][idx];
         pixB[k] = histB[k][idx];
      end else begin
         pixR[k] = 8'h77;
         pixG[k] = 8'h77;
         pixB[k] = 8'h77;
      end
   endtask

   task automatic checkOutput(input int k);
      logic     act, hs, vs, have;
      int       xe, ye;
      sbEntry_t e;
      act = (mh[k] < H_ACT[k]) && (mv[k] < V_ACT[k]);
      hs  = (mh[k] >= H_ACT[k] + H_FPO[k]) && (mh[k] < H_ACT[k] + H_FPO[k] + H_SW[k]);
      vs  = (mv[k] >= V_ACT[k] + V_FPO[k]) && (mv[k] < V_ACT[k] + V_FPO[k] + V_SW[k]);
      xe  = act ? mh[k] : 0;
      ye  = act ? mv[k] : 0;
      checkVal("pix_valid", k, pvO[k], act);
      checkVal("x", k, xO[k], xe);
      checkVal("y", k, yO[k], ye);
      checkVal("frame_start", k, fsO[k], (mh[k] == 0 && mv[k] == 0));
      checkVal("line_start", k, lsO[k], (mh[k] == 0 && mv[k] < V_ACT[k]));

      have = 1'b0;
      if (k == 0) begin
         if (sbQ0.size() > 0 && sbQ0[0].due == cyc) begin
            e = sbQ0.pop_front();
            have = 1'b1;
         end
      end else begin
         if (sbQ1.size() > 0 && sbQ1[0].due == cyc) begin
            e = sbQ1.pop_front();
            have = 1'b1;
         end
      end
      if (have) begin
         checkVal("red", k, redO[k], e.r);
         checkVal("green", k, greenO[k], e.g);
         checkVal("blue", k, blueO[k], e.b);
         checkVal("blank_n", k, blankO[k], e.act);
         checkVal("h_sync", k, hsO[k], e.hs ? H_PL[k] : !H_PL[k]);
         checkVal("v_sync", k, vsO[k], e.vs ? V_PL[k] : !V_PL[k]);
         checkVal("sync_n", k, syncNO[k], SOGP[k] ? !(e.hs || e.vs) : 1'b1);
      end else begin
         checkVal("blank_n startup", k, blankO[k], 0);
         checkVal("red startup", k, redO[k], 0);
         checkVal("h_sync startup", k, hsO[k], !H_PL[k]);
      end

      e.due = cyc + LAT[k] + 1;
      e.act = act;
      e.hs  = hs;
      e.vs  = vs;
      e.r   = act ? colR(xe) : 8'h00;
      e.g   = act ? colG(ye) : 8'h00;
      e.b   = act ? colB(xe, ye) : 8'h00;
      if (k == 0) sbQ0.push_back(e);
      else sbQ1.push_back(e);

      histR[k][cyc % 8] = colR(xe);
      histG[k][cyc % 8] = colG(ye);
      histB[k][cyc % 8] = colB(xe, ye);
      applyStimulus(k);
   endtask

   task automatic checkResetValues(input int k);
      checkVal("reset red", k, redO[k], 0);
      checkVal("reset green", k, greenO[k], 0);
      checkVal("reset blue", k, blueO[k], 0);
      checkVal("reset blank_n", k, blankO[k], 0);
      checkVal("reset h_sync", k, hsO[k], !H_PL[k]);
      checkVal("reset v_sync", k, vsO[k], !V_PL[k]);
      checkVal("reset sync_n", k, syncNO[k], 1);
      checkVal("reset pix_valid", k, pvO[k], 0);
      checkVal("reset x", k, xO[k], 0);
      checkVal("reset y", k, yO[k], 0);
      checkVal("reset frame_start", k, fsO[k], 0);
      checkVal("reset line_start", k, lsO[k], 0);
   endtask

   task automatic advanceModel(input int k);
      if (mh[k] == hTot(k) - 1) begin
         mh[k] = 0;
         mv[k] = (mv[k] == vTot(k) - 1) ? 0 : mv[k] + 1;
      end else begin
         mh[k] = mh[k] + 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (!inReset) begin
         cyc++;
         for (int k = 0; k < 2; k++) advanceModel(k);
         for (int k = 0; k < 2; k++) checkOutput(k);
      end
   endtask

   task automatic startRun();
      cyc = 0;
      inReset = 1'b0;
      sbQ0.delete();
      sbQ1.delete();
      for (int k = 0; k < 2; k++) begin
         mh[k] = 0;
         mv[k] = 0;
      end
      for (int k = 0; k < 2; k++) checkOutput(k);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n, hsCnt, vsCnt, blCnt, snCnt, fsCnt, firstA, firstB;
      bit hit;

      probes[0]  = '{0, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1};
      probes[1]  = '{0, 5, 0, 1'b1, 5, 0, 1'b0, 1'b0};
      probes[2]  = '{0, 15, 1, 1'b1, 15, 1, 1'b0, 1'b0};
      probes[3]  = '{0, 16, 1, 1'b0, 0, 0, 1'b0, 1'b0};
      probes[4]  = '{0, 0, 2, 1'b1, 0, 2, 1'b0, 1'b1};
      probes[5]  = '{0, 24, 5, 1'b0, 0, 0, 1'b0, 1'b0};
      probes[6]  = '{0, 0, 6, 1'b0, 0, 0, 1'b0, 1'b0};
      probes[7]  = '{0, 3, 9, 1'b0, 0, 0, 1'b0, 1'b0};
      probes[8]  = '{1, 0, 0, 1'b1, 0, 0, 1'b1, 1'b1};
      probes[9]  = '{1, 11, 4, 1'b1, 11, 4, 1'b0, 1'b0};
      probes[10] = '{1, 0, 5, 1'b0, 0, 0, 1'b0, 1'b0};
      probes[11] = '{1, 23, 10, 1'b0, 0, 0, 1'b0, 1'b0};

      inReset = 1'b1;
      reset   = 1'b1;
      for (int k = 0; k < 2; k++) begin
         pixR[k] = 8'hFF;
         pixG[k] = 8'hFF;
         pixB[k] = 8'hFF;
      end
      repeat (3) tick();
      for (int k = 0; k < 2; k++) checkResetValues(k);

      reset = 1'b0;
      #1;
      startRun();

      for (int i = 0; i < 12; i++) begin
         n = 0;
         while (!(mh[probes[i].k] == probes[i].h && mv[probes[i].k] == probes[i].v) && n < 600) begin
            tick();
            n++;
         end
         hit = (mh[probes[i].k] == probes[i].h && mv[probes[i].k] == probes[i].v);
         checkVal("probe reached", probes[i].k, hit, 1);
         checkVal("probe pix_valid", probes[i].k, pvO[probes[i].k], probes[i].pv);
         checkVal("probe x", probes[i].k, xO[probes[i].k], probes[i].x);
         checkVal("probe y", probes[i].k, yO[probes[i].k], probes[i].y);
         checkVal("probe frame_start", probes[i].k, fsO[probes[i].k], probes[i].fs);
         checkVal("probe line_start", probes[i].k, lsO[probes[i].k], probes[i].ls);
      end

      // One full frame of the negative-polarity mode (25 x 10 clocks).
      hsCnt = 0; vsCnt = 0; blCnt = 0; fsCnt = 0;
      for (int i = 0; i < 250; i++) begin
         tick();
         hsCnt += (hsO[0] == 1'b0) ? 1 : 0;
         vsCnt += (vsO[0] == 1'b0) ? 1 : 0;
         blCnt += (blankO[0] == 1'b1) ? 1 : 0;
         fsCnt += (fsO[0] == 1'b1) ? 1 : 0;
      end
      checkVal("frame h_sync low clocks", 0, hsCnt, 30);
      checkVal("frame v_sync low clocks", 0, vsCnt, 50);
      checkVal("frame blank_n high clocks", 0, blCnt, 96);
      checkVal("frame_start pulses per frame", 0, fsCnt, 1);

      // One full frame of the positive-polarity SOG mode (24 x 11 clocks).
      hsCnt = 0; vsCnt = 0; blCnt = 0; snCnt = 0;
      for (int i = 0; i < 264; i++) begin
         tick();
         hsCnt += (hsO[1] == 1'b1) ? 1 : 0;
         vsCnt += (vsO[1] == 1'b1) ? 1 : 0;
         blCnt += (blankO[1] == 1'b1) ? 1 : 0;
         snCnt += (syncNO[1] == 1'b0) ? 1 : 0;
      end
      checkVal("frame h_sync high clocks", 1, hsCnt, 44);
      checkVal("frame v_sync high clocks", 1, vsCnt, 72);
      checkVal("frame blank_n high clocks", 1, blCnt, 60);
      checkVal("frame sync_n low clocks", 1, snCnt, 104);

      for (int k = 0; k < 2; k++) begin
         n = 0;
         while (fsO[k] !== 1'b1 && n < 300) begin
            tick();
            n++;
         end
         checkVal("frame_start found", k, fsO[k], 1);
         n = 0;
         do begin
            tick();
            n++;
         end while (fsO[k] !== 1'b1 && n < 300);
         checkVal("frame period", k, n, (k == 0) ? 250 : 264);
      end

      // Reset in the middle of a visible line.
      n = 0;
      while (!(mh[0] == 10 && mv[0] == 3) && n < 300) begin
         tick();
         n++;
      end
      checkVal("mid-frame point reached", 0, (mh[0] == 10 && mv[0] == 3), 1);
      checkVal("pre-reset blank_n", 0, blankO[0], 1);
      reset = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) checkResetValues(k);
      inReset = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < 2; k++) checkResetValues(k);
      reset = 1'b0;
      #1;
      startRun();
      checkVal("restart frame_start", 0, fsO[0], 1);
      checkVal("restart frame_start", 1, fsO[1], 1);

      firstA = -1;
      firstB = -1;
      for (int i = 0; i < 10; i++) begin
         if (blankO[0] === 1'b1 && firstA < 0) firstA = i;
         if (blankO[1] === 1'b1 && firstB < 0) firstB = i;
         tick();
      end
      checkVal("blank_n rise delay", 0, firstA, 3);
      checkVal("blank_n rise delay", 1, firstB, 1);

      repeat (60) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
